// File: rtl/wasm_fetch_decode_pkg.sv
// Shared decode definitions for the WebAssembly front end: immediate kinds,
// fault codes and the opcode values the execute stage also relies on.
package wasm_decode_pkg;

    localparam int MAX_LEN = 11;

    typedef enum logic [2:0] {
        KIND_NONE,
        KIND_BYTE1,
        KIND_VARU32,
        KIND_VARS32,
        KIND_VARS64,
        KIND_FIX4,
        KIND_FIX8
    } imm_kind_t;

    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_ROM  = 2'd1;
    localparam logic [1:0] FAULT_LEB  = 2'd2;

    localparam logic [7:0] OP_NOP       = 8'h01;
    localparam logic [7:0] OP_BLOCK     = 8'h02;
    localparam logic [7:0] OP_LOOP      = 8'h03;
    localparam logic [7:0] OP_IF        = 8'h04;
    localparam logic [7:0] OP_END       = 8'h0B;
    localparam logic [7:0] OP_BR        = 8'h0C;
    localparam logic [7:0] OP_BR_IF     = 8'h0D;
    localparam logic [7:0] OP_CALL      = 8'h10;
    localparam logic [7:0] OP_I32_CONST = 8'h41;
    localparam logic [7:0] OP_I64_CONST = 8'h42;
    localparam logic [7:0] OP_F32_CONST = 8'h43;
    localparam logic [7:0] OP_F64_CONST = 8'h44;

    function automatic imm_kind_t imm_kind(input logic [7:0] op);
        case (op)
            OP_BLOCK, OP_LOOP, OP_IF:                      return KIND_BYTE1;
            OP_BR, OP_BR_IF, OP_CALL,
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24:             return KIND_VARU32;
            OP_I32_CONST:                                  return KIND_VARS32;
            OP_I64_CONST:                                  return KIND_VARS64;
            OP_F32_CONST:                                  return KIND_FIX4;
            OP_F64_CONST:                                  return KIND_FIX8;
            default:                                       return KIND_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wasm_fetch_decode_if.sv
// Decoded-instruction channel from the fetch/decode front end to execute.
interface wasm_fetch_decode_if #(parameter int ADDR_W = 16);
    logic              ins_valid;
    logic              ins_ready;
    logic [7:0]        ins_opcode;
    logic [63:0]       ins_imm;
    logic [ADDR_W-1:0] ins_pc;
    logic [3:0]        ins_len;

    modport master (output ins_valid, ins_opcode, ins_imm, ins_pc, ins_len,
                    input  ins_ready);
    modport slave  (input  ins_valid, ins_opcode, ins_imm, ins_pc, ins_len,
                    output ins_ready);
endinterface

// File: rtl/wasm_fetch_decode_leb.sv
// One LEB128 byte step: merge payload at 7*idx, sign-extend on the final byte,
// and flag a continuation bit left set on the last legal byte.
module leb128_step (
    input  logic [63:0] acc_i,
    input  logic [7:0]  byte_i,
    input  logic [3:0]  idx_i,
    input  logic        signed_i,
    input  logic        wide_i,
    output logic [63:0] acc_o,
    output logic        done_o,
    output logic        overlong_o
);
    logic [6:0]  shamt;
    logic [6:0]  nbits;
    logic [63:0] merged;
    logic [63:0] ext;

    always_comb begin
        shamt      = 7'(idx_i) * 7'd7;
        nbits      = shamt + 7'd7;
        merged     = acc_i | ({57'd0, byte_i[6:0]} << shamt);
        done_o     = !byte_i[7];
        overlong_o = byte_i[7] && (idx_i == (wide_i ? 4'd9 : 4'd4));
        ext        = merged;
        // Shifting by 64 or more yields zero, so a full-width value gets no fill.
        if (done_o && signed_i && byte_i[6])
            ext = merged | ~((64'd1 << nbits) - 64'd1);
        acc_o = wide_i ? ext : {32'd0, ext[31:0]};
    end
endmodule

// File: rtl/wasm_fetch_decode.sv
// Fetch/decode front end: streams ROM bytes and delivers one assembled
// instruction (opcode, immediate, length) per valid/ready handshake.
module wasm_fetch_decode
    import wasm_decode_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  mem_addr_o,
    input  logic [7:0]         mem_data_i,
    input  logic               mem_error_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic [1:0]         fault_o,
    wasm_fetch_decode_if.master ins
);
    // state   | meaning
    // FETCH   | present opcode address
    // OPC     | opcode byte arrives, classify immediate
    // IMM     | consume one immediate byte per cycle
    // OUT     | instruction valid, wait for ready
    // FAULT   | stopped until reset
    typedef enum logic [2:0] {S_FETCH, S_OPC, S_IMM, S_OUT, S_FAULT} state_t;

    state_t            state_q, state_d;
    imm_kind_t         kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [63:0]       imm_q, imm_d;
    logic [3:0]        len_q, len_d;
    logic [1:0]        fault_q, fault_d;

    logic [3:0]  idx;
    logic [63:0] leb_acc, fix_acc;
    logic        leb_done, leb_over, fix_last, byte_done;

    assign idx     = len_q - 4'd1;
    assign fix_acc = imm_q | ({56'd0, mem_data_i} << {idx, 3'b000});
    assign fix_last = (kind_q == KIND_FIX4) ? (idx == 4'd3) : (idx == 4'd7);

    leb128_step u_leb (
        .acc_i      (imm_q),
        .byte_i     (mem_data_i),
        .idx_i      (idx),
        .signed_i   (kind_q == KIND_VARS32 || kind_q == KIND_VARS64),
        .wide_i     (kind_q == KIND_VARS64),
        .acc_o      (leb_acc),
        .done_o     (leb_done),
        .overlong_o (leb_over)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        imm_d     = imm_q;
        len_d     = len_q;
        fault_d   = fault_q;
        byte_done = 1'b0;

        if (redirect_i && fault_q == FAULT_NONE) begin
            state_d = S_FETCH;
            addr_d  = redirect_pc_i;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    pc_d    = addr_q;
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_OPC;
                end
                S_OPC: begin
                    if (mem_error_i) begin
                        fault_d = FAULT_ROM;
                        state_d = S_FAULT;
                    end else begin
                        opcode_d = mem_data_i;
                        kind_d   = imm_kind(mem_data_i);
                        imm_d    = 64'd0;
                        len_d    = 4'd1;
                        if (imm_kind(mem_data_i) == KIND_NONE) begin
                            valid_d = 1'b1;
                            state_d = S_OUT;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_IMM;
                        end
                    end
                end
                S_IMM: begin
                    if (mem_error_i) begin
                        fault_d = FAULT_ROM;
                        state_d = S_FAULT;
                    end else if (kind_q != KIND_BYTE1 && kind_q != KIND_FIX4 &&
                                 kind_q != KIND_FIX8 && leb_over) begin
                        fault_d = FAULT_LEB;
                        state_d = S_FAULT;
                    end else begin
                        len_d = len_q + 4'd1;
                        case (kind_q)
                            KIND_BYTE1: begin
                                imm_d     = {56'd0, mem_data_i};
                                byte_done = 1'b1;
                            end
                            KIND_FIX4, KIND_FIX8: begin
                                imm_d     = fix_acc;
                                byte_done = fix_last;
                            end
                            default: begin
                                imm_d     = leb_acc;
                                byte_done = leb_done;
                            end
                        endcase
                        if (byte_done) begin
                            valid_d = 1'b1;
                            state_d = S_OUT;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (ins.ins_ready) begin
                        valid_d = 1'b0;
                        addr_d  = pc_q + ADDR_W'(len_q);
                        state_d = S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            kind_q   <= KIND_NONE;
            addr_q   <= '0;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            opcode_q <= 8'd0;
            imm_q    <= 64'd0;
            len_q    <= 4'd0;
            fault_q  <= FAULT_NONE;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            len_q    <= len_d;
            fault_q  <= fault_d;
        end
    end

    assign mem_addr_o     = addr_q;
    assign fault_o        = fault_q;
    assign ins.ins_valid  = valid_q;
    assign ins.ins_opcode = opcode_q;
    assign ins.ins_imm    = imm_q;
    assign ins.ins_pc     = pc_q;
    assign ins.ins_len    = len_q;
endmodule

// File: tb/tb_wasm_fetch_decode.sv
// Bench for wasm_fetch_decode: ROM model, instruction table with scoreboard,
// and directed sequences for stall, fault, redirect and ROM error.
module tb_wasm_fetch_decode;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_error;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [1:0]  fault;

    wasm_fetch_decode_if #(.ADDR_W(16)) ins_if ();

    wasm_fetch_decode #(.ADDR_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_addr_o    (mem_addr),
        .mem_data_i    (mem_data),
        .mem_error_i   (mem_error),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fault_o       (fault),
        .ins           (ins_if)
    );

    always #5 clk = ~clk;

    logic [7:0]  rom [256];
    logic [16:0] rom_limit;

    always @(posedge clk) begin
        mem_data  <= rom[mem_addr[7:0]];
        mem_error <= ({1'b0, mem_addr} >= rom_limit);
    end

    typedef struct {
        logic [7:0]  op;
        logic [63:0] imm;
        logic [15:0] pc;
        logic [3:0]  len;
    } exp_t;

    typedef struct {
        int          n;
        logic [87:0] raw;
        logic [63:0] imm;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    exp_t got;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && ins_if.ins_valid && ins_if.ins_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_accept: got pc %h opcode %h, want no instruction",
                         ins_if.ins_pc, ins_if.ins_opcode);
            end else begin
                got = sb.pop_front();
                chk("opcode", 64'(ins_if.ins_opcode), 64'(got.op));
                chk("imm",    ins_if.ins_imm,         got.imm);
                chk("pc",     64'(ins_if.ins_pc),     64'(got.pc));
                chk("len",    64'(ins_if.ins_len),    64'(got.len));
            end
        end
    end

    task automatic addv(input int n, input logic [87:0] raw, input logic [63:0] imm);
        vec_t v;
        v.n = n; v.raw = raw; v.imm = imm;
        vecs.push_back(v);
    endtask

    task automatic load(input int base, input int n, input logic [87:0] raw);
        for (int i = 0; i < n; i++) rom[(base + i) % 256] = raw[8*(n-1-i) +: 8];
    endtask

    task automatic expect_ins(input logic [7:0] op, input logic [63:0] imm,
                              input logic [15:0] pc, input logic [3:0] len);
        exp_t e;
        e.op = op; e.imm = imm; e.pc = pc; e.len = len;
        sb.push_back(e);
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 8'h01;
        rom_limit = 17'd256;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        redirect = 1'b0;
        ins_if.ins_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        int c = 0;
        while (sb.size() != 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending, want 0", name, sb.size());
            sb.delete();
        end
        ins_if.ins_ready = 1'b0;
    endtask

    task automatic pulse_redirect(input logic [15:0] pc);
        redirect = 1'b1;
        redirect_pc = pc;
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    initial begin
        int   pcv;
        int   cnt;
        logic saw;

        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0;
        ins_if.ins_ready = 1'b0;
        rom_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_addr", 64'(mem_addr), 64'h0);
        chk("rst_valid",    64'(ins_if.ins_valid), 64'h0);
        chk("rst_opcode",   64'(ins_if.ins_opcode), 64'h0);
        chk("rst_imm",      ins_if.ins_imm, 64'h0);
        chk("rst_pc",       64'(ins_if.ins_pc), 64'h0);
        chk("rst_len",      64'(ins_if.ins_len), 64'h0);
        chk("rst_fault",    64'(fault), 64'h0);

        addv(1,  8'h01,                         64'h0);
        addv(1,  8'h0B,                         64'h0);
        addv(2,  16'h417F,                      64'h00000000_FFFFFFFF);
        addv(3,  24'h428001,                    64'h80);
        addv(2,  16'h427F,                      64'hFFFFFFFF_FFFFFFFF);
        addv(5,  40'h430000803F,                64'h3F800000);
        addv(9,  72'h44_000000000000_F03F,      64'h3FF00000_00000000);
        addv(2,  16'h0240,                      64'h40);
        addv(4,  32'h20E58E26,                  64'h98765);
        addv(3,  24'h41807F,                    64'h00000000_FFFFFF80);
        addv(11, 88'h42_FFFFFFFFFFFFFFFFFF_01,  64'hFFFFFFFF_FFFFFFFF);
        addv(6,  48'h10FFFFFFFF0F,              64'h00000000_FFFFFFFF);

        pcv = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            load(pcv, vecs[i].n, vecs[i].raw);
            expect_ins(vecs[i].raw[8*(vecs[i].n-1) +: 8], vecs[i].imm,
                       16'(pcv), 4'(vecs[i].n));
            pcv += vecs[i].n;
        end
        reset_dut();
        ins_if.ins_ready = 1'b1;
        chk("cycle0_valid", 64'(ins_if.ins_valid), 64'h0);
        cnt = 0;
        while (!ins_if.ins_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("first_valid_cycle", 64'(cnt), 64'd2);
        wait_empty("table", 400);

        // Back-pressure: outputs must hold while ready is low.
        rom_clear();
        load(0, 3, 24'h410501);
        expect_ins(8'h41, 64'd5, 16'h0, 4'd2);
        expect_ins(8'h01, 64'd0, 16'h2, 4'd1);
        reset_dut();
        cnt = 0;
        while (!ins_if.ins_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid",  64'(ins_if.ins_valid), 64'h1);
            chk("stall_opcode", 64'(ins_if.ins_opcode), 64'h41);
            chk("stall_imm",    ins_if.ins_imm, 64'd5);
            chk("stall_pc",     64'(ins_if.ins_pc), 64'h0);
            chk("stall_len",    64'(ins_if.ins_len), 64'd2);
            @(posedge clk); #1;
        end
        ins_if.ins_ready = 1'b1;
        wait_empty("stall", 50);

        // Overlong i32.const: continuation still set on the 5th byte.
        rom_clear();
        load(0, 6, 48'h418080808080);
        reset_dut();
        ins_if.ins_ready = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ins_if.ins_valid) saw = 1'b1;
        end
        chk("overlong_valid", 64'(saw), 64'h0);
        chk("overlong_fault", 64'(fault), 64'h2);
        chk("overlong_addr",  64'(mem_addr), 64'h6);
        repeat (3) @(posedge clk);
        #1;
        chk("overlong_addr_hold", 64'(mem_addr), 64'h6);
        reset_dut();
        chk("post_reset_fault", 64'(fault), 64'h0);
        chk("post_reset_addr",  64'(mem_addr), 64'h0);

        // Redirect in the middle of an i64.const immediate.
        rom_clear();
        load(0, 6, 48'h428080808001);
        load(16, 1, 8'h0B);
        expect_ins(8'h0B, 64'd0, 16'h10, 4'd1);
        reset_dut();
        ins_if.ins_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulse_redirect(16'h0010);
        wait_empty("redirect", 50);

        // ROM error on an opcode fetch, then a redirect that must be ignored.
        rom_limit = 17'h20;
        pulse_redirect(16'h0030);
        repeat (6) @(posedge clk);
        #1;
        chk("romerr_fault", 64'(fault), 64'h1);
        chk("romerr_valid", 64'(ins_if.ins_valid), 64'h0);
        chk("romerr_addr",  64'(mem_addr), 64'h31);
        pulse_redirect(16'h0000);
        repeat (3) @(posedge clk);
        #1;
        chk("faulted_redirect_fault", 64'(fault), 64'h1);
        chk("faulted_redirect_addr",  64'(mem_addr), 64'h31);
        reset_dut();
        chk("romerr_reset_fault", 64'(fault), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
